// File: rtl/msx_bus_pkg.sv
// msx_bus_pkg: shared bus-cycle types and wait-state sizing for the MSX slot master.
package msx_bus_pkg;

  // Width of the programmable wait-state counter (covers 0-3 extra TW states).
  localparam int WAIT_W = 2;

  // T-state sequence of one MSX bus cycle.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4
  } bus_state_e;

  // Cycle type: {io, we}.
  typedef enum logic [1:0] {
    CYC_MEM_RD = 2'b00,
    CYC_MEM_WR = 2'b01,
    CYC_IO_RD  = 2'b10,
    CYC_IO_WR  = 2'b11
  } cycle_e;

  // Chooses the wait-state preload for a cycle: I/O cycles get their own count.
  function automatic logic [WAIT_W-1:0] wait_preload(input logic io,
                                                     input logic [WAIT_W-1:0] mem_wait,
                                                     input logic [WAIT_W-1:0] io_wait);
    return io ? io_wait : mem_wait;
  endfunction

endpackage

// File: rtl/msx_sync2.sv
// msx_sync2: two-flop synchronizer for asynchronous active-low slave signals.
// Both flops reset to 1 so an idle (deasserted) line is seen during reset.
module msx_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage shift toward the clk domain; resets to the inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/msx_slot_master.sv
// msx_slot_master: single-outstanding MSX bus master generating slot 3 memory and
// I/O read/write cycles (T1, T2, optional TW, T3) paced by the bus clock enable.
module msx_slot_master
  import msx_bus_pkg::*;
#(
  parameter int EXTRA_WAIT = 0,
  parameter int IO_WAIT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        req,
  input  logic        req_we,
  input  logic        req_io,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        dout_en,
  input  logic [7:0]  din,
  output logic        rd_n,
  output logic        wr_n,
  output logic        slt3_n,
  output logic        iorq_n,
  output logic        m1_n,
  input  logic        wait_n,
  input  logic        int_n,
  output logic        irq
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_T1   = ST_T1;
  localparam logic [2:0] S_T2   = ST_T2;
  localparam logic [2:0] S_TW   = ST_TW;
  localparam logic [2:0] S_T3   = ST_T3;

  localparam logic [WAIT_W-1:0] MEM_WAIT_CNT = WAIT_W'(EXTRA_WAIT);
  localparam logic [WAIT_W-1:0] IO_WAIT_CNT  = WAIT_W'(IO_WAIT);

  logic [2:0]        state;
  logic              pend;
  cycle_e            cyc;
  logic              cyc_io;
  logic              cyc_we;
  logic [15:0]       lat_addr;
  logic [7:0]        lat_wdata;
  logic [WAIT_W-1:0] wcnt;
  logic              wait_s;
  logic              int_s;
  logic              accept;

  msx_sync2 u_wait_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (wait_n),
    .q     (wait_s)
  );

  msx_sync2 u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (int_n),
    .q     (int_s)
  );

  assign {cyc_io, cyc_we} = cyc;

  // A request is taken only from a truly idle master: not already pending and not
  // in the ack clock, so a strobe overlapping ack never starts a second cycle.
  assign accept = req && (state == S_IDLE) && !pend && !ack;
  assign busy   = pend || (state != S_IDLE) || ack;
  assign irq    = ~int_s;
  assign m1_n   = 1'b1;

  // Bus cycle sequencer: request capture, T-state progression and strobe generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pend      <= 1'b0;
      cyc       <= CYC_MEM_RD;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wcnt      <= '0;
      addr      <= '0;
      dout      <= '0;
      dout_en   <= 1'b0;
      rdata     <= '0;
      ack       <= 1'b0;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      slt3_n    <= 1'b1;
      iorq_n    <= 1'b1;
    end else begin
      ack <= 1'b0;
      if (accept) begin
        pend      <= 1'b1;
        cyc       <= cycle_e'({req_io, req_we});
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        wcnt      <= wait_preload(req_io, MEM_WAIT_CNT, IO_WAIT_CNT);
      end
      if (cen) begin
        case (state)
          S_IDLE: begin
            if (pend) begin
              pend  <= 1'b0;
              state <= S_T1;
              addr  <= lat_addr;
              if (cyc_we) begin
                dout    <= lat_wdata;
                dout_en <= 1'b1;
              end
            end
          end
          S_T1: begin
            state <= S_T2;
            if (cyc_io) iorq_n <= 1'b0;
            else        slt3_n <= 1'b0;
            if (cyc_we) wr_n <= 1'b0;
            else        rd_n <= 1'b0;
          end
          S_T2: begin
            if ((wcnt != '0) || !wait_s) state <= S_TW;
            else                         state <= S_T3;
          end
          S_TW: begin
            if (wcnt != '0) wcnt <= wcnt - WAIT_W'(1);
            // The count seen here is pre-decrement: one TW per preloaded unit.
            if ((wcnt > WAIT_W'(1)) || !wait_s) state <= S_TW;
            else                                state <= S_T3;
          end
          S_T3: begin
            state   <= S_IDLE;
            ack     <= 1'b1;
            dout_en <= 1'b0;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            slt3_n  <= 1'b1;
            iorq_n  <= 1'b1;
            if (!cyc_we) rdata <= din;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/msx_slot_master.md
MSX_SLOT_MASTER -- requirements
Module: msx_slot_master

Interface
REQ-001 SHALL have parameter EXTRA_WAIT, default 0, extra TW states added to every memory cycle (0-3).
REQ-002 SHALL have parameter IO_WAIT, default 1, automatic TW states added to every I/O cycle (0-3).
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cen  in  1  bus clock enable (3.579545 MHz rate); bus state advances only when cen=1.
REQ-006 req  in  1  request strobe; sampled in IDLE only.
REQ-007 req_we  in  1  1=write cycle, 0=read cycle.
REQ-008 req_io  in  1  1=I/O cycle (iorq_n), 0=slot 3 memory cycle (slt3_n).
REQ-009 req_addr  in  16  cycle address.
REQ-010 req_wdata  in  8  write data.
REQ-011 ack  out  1  one-clk pulse at cycle completion.
REQ-012 rdata  out  8  read data, valid from ack, held until next read ack.
REQ-013 busy  out  1  high from request acceptance to ack inclusive.
REQ-014 addr  out  16  MSX address bus.
REQ-015 dout  out  8  MSX data bus drive value.
REQ-016 dout_en  out  1  MSX data bus output enable.
REQ-017 din  in  8  MSX data bus sampled value.
REQ-018 rd_n, wr_n, slt3_n, iorq_n, m1_n  out  1 each  MSX bus control strobes, active-low.
REQ-019 wait_n  in  1  slave WAIT request, active-low, asynchronous to clk.
REQ-020 int_n  in  1  slave interrupt, active-low, asynchronous to clk.
REQ-021 irq  out  1  synchronized, active-high interrupt level.

Function
REQ-022 SHALL implement FSM states IDLE, T1, T2, TW, T3; transitions occur only on clk edges with cen=1, except IDLE acceptance.
REQ-023 IDLE: req=1 on any clk latches req_we/req_io/req_addr/req_wdata, sets busy, enters T1 at the next cen.
REQ-024 T1: addr=latched address; for write, dout=latched data and dout_en=1 from T1 through T3.
REQ-025 T2: memory cycle asserts slt3_n=0 and rd_n or wr_n=0; I/O cycle asserts iorq_n=0 and rd_n or wr_n=0; strobes held low through T3.
REQ-026 End of T2: enters TW if the wait-state counter (preloaded with EXTRA_WAIT or IO_WAIT) is nonzero or synchronized wait_n=0, else T3.
REQ-027 TW: decrements counter per cen; stays while counter>0 or synchronized wait_n=0; unbounded while wait_n=0.
REQ-028 T3: read captures din into rdata on the T3 cen edge; all strobes, dout_en deassert and ack pulses on that same edge; state returns to IDLE.
REQ-029 m1_n SHALL remain 1 at all times (no opcode-fetch cycles).
REQ-030 Minimum latency with zero waits: exactly 3 cen periods from T1 entry to ack.
REQ-031 req while busy SHALL be ignored; no queueing.
REQ-032 req asserted on the same clk as ack is ignored; a new cycle needs req in IDLE.
REQ-033 addr holds its last value in IDLE; dout_en=0 in IDLE.
REQ-034 wait_n and int_n SHALL pass through two-flop synchronizers before use; irq = ~synchronized int_n.
REQ-035 slt3_n and iorq_n SHALL never be low simultaneously; rd_n and wr_n likewise.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE, rd_n=wr_n=slt3_n=iorq_n=m1_n=1, dout_en=0, ack=0, busy=0, irq=0, addr=0, dout=0, rdata=0, synchronizers to 1.
REQ-037 Reset mid-cycle aborts without ack; the first cycle after reset release requires a fresh req.

Structure
REQ-038 Package msx_bus_pkg SHALL hold the FSM state enum, cycle-type encoding and wait-count width constant.
REQ-039 Sub-module msx_sync2 (two-flop synchronizer, reset to 1) SHALL be instantiated for wait_n and int_n.

Verification
REQ-040 Memory read, addr 3FF0, din=0x5A, wait_n=1, EXTRA_WAIT=0 -> slt3_n,rd_n low T2-T3, ack after 3 cen, rdata=0x5A.
REQ-041 Memory write, addr 3FF1, data 0x20 -> dout_en=1 and dout=0x20 T1-T3, wr_n low T2-T3, iorq_n stays 1.
REQ-042 I/O read, addr 0x00A8, IO_WAIT=1 -> iorq_n low, one TW, ack after 4 cen, slt3_n stays 1.
REQ-043 Memory read with wait_n low for 5 cen from T2 -> stays in TW, ack 3 cen after wait_n release propagates, strobes stable throughout.
REQ-044 rst_n pulsed low during TW -> all strobes high within reset, no ack, next req completes normally.
REQ-045 int_n driven low -> irq=1 within 2 clk; req during busy ignored, no second ack.
